// File: rtl/uart_rx.sv
`default_nettype none
// ==== uart_rx : oversampled 8N1 UART receiver with framing-error flag; rev 1.0 ====
// ==== Optional even-parity bit (and o_Parity_Err port) when UART_RX_PARITY_EN is defined ====
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_reset,
  input  logic                 i_bd,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Done,
  output logic                 o_Rx_Active,
  output logic                 o_Frame_Err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_Parity_Err
`endif
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [TICK_W-1:0]    tick, tick_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] byte_nxt;
  logic                 done_nxt, ferr_nxt;
  logic                 mid_half, mid_full;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt, perr_nxt;
`endif

  // Both flops preset to 1 so reset looks like an idle line
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  assign mid_half = i_bd && (tick == TICK_HALF);
  assign mid_full = i_bd && (tick == TICK_FULL);

  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      tick        <= '0;
      idx         <= '0;
      shreg       <= '0;
      o_Rx_Byte   <= '0;
      o_Rx_Done   <= 1'b0;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      tick        <= tick_nxt;
      idx         <= idx_nxt;
      shreg       <= shreg_nxt;
      o_Rx_Byte   <= byte_nxt;
      o_Rx_Done   <= done_nxt;
      o_Rx_Active <= (state_nxt != IDLE);
      o_Frame_Err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_nxt;
      o_Parity_Err <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = i_bd ? tick + 1'b1 : tick;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    byte_nxt  = o_Rx_Byte;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        tick_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (mid_half) begin
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid_full) begin
          tick_nxt  = '0;
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          idx_nxt   = idx + 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_full) begin
          par_nxt   = rx_s;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_full) begin
          state_nxt = IDLE;
          if (rx_s) begin
            byte_nxt = shreg;
            done_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_nxt = ^{shreg, par_bit};
`endif
          end else begin
            ferr_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every state change restarts the bit-phase count
    if (state_nxt != state) tick_nxt = '0;
  end

endmodule
`default_nettype wire
